// File: rtl/key_bounce_if.sv
// Handshake bundle between a key-bounce generator and whatever drives or observes it.
interface key_bounce_if;
  logic press_req;
  logic key_out;
  logic busy;
  logic done;

  modport master (output press_req, input key_out, input busy, input done);
  modport slave  (input press_req, output key_out, output busy, output done);
endinterface

// File: rtl/key_bounce_gen.sv
// Emulated active-low key: one press_req yields press bounce, stable hold, release bounce, then done.
// Define RANDOM_BOUNCE_EN to gate bounce toggles with a 16-bit LFSR for irregular bounce.
//
// state | meaning
// IDLE  | key released, waiting for press_req
// P_BNC | press bounce window
// HOLD  | key held stable low
// R_BNC | release bounce window
module key_bounce_gen #(
  parameter logic [23:0] BOUNCE_CNT = 24'd249_999,
  parameter logic [23:0] HOLD_CNT   = 24'd4_999_999,
  parameter logic [23:0] TOGGLE_DIV = 24'd9_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  key_bounce_if.slave kb
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    P_BNC = 4'b0010,
    HOLD  = 4'b0100,
    R_BNC = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_win_q, cnt_win_d;
  logic [23:0] cnt_tgl_q, cnt_tgl_d;
  logic        key_out_q, key_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tgl_en;
  logic        tgl_wrap;

`ifdef RANDOM_BOUNCE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Taps 16,14,13,11 in right-shift form; bit 0 is the output.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign tgl_en = lfsr_q[0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lfsr_q <= 16'hACE1;
    else            lfsr_q <= lfsr_d;
  end
`else
  assign tgl_en = 1'b1;
`endif

  assign tgl_wrap = (cnt_tgl_q == TOGGLE_DIV);

  always_comb begin
    state_d   = state_q;
    cnt_win_d = cnt_win_q + 24'd1;
    cnt_tgl_d = '0;
    key_out_d = key_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_win_d = '0;
        key_out_d = 1'b1;
        busy_d    = 1'b0;
        if (kb.press_req) begin
          state_d   = P_BNC;
          key_out_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      P_BNC: begin
        cnt_tgl_d = tgl_wrap ? 24'd0 : cnt_tgl_q + 24'd1;
        if (cnt_win_q == BOUNCE_CNT) begin
          state_d   = HOLD;
          key_out_d = 1'b0;
          cnt_win_d = '0;
          cnt_tgl_d = '0;
        end else if (tgl_wrap && tgl_en) begin
          key_out_d = ~key_out_q;
        end
      end
      HOLD: begin
        key_out_d = 1'b0;
        if (cnt_win_q == HOLD_CNT) begin
          state_d   = R_BNC;
          key_out_d = 1'b1;
          cnt_win_d = '0;
        end
      end
      R_BNC: begin
        cnt_tgl_d = tgl_wrap ? 24'd0 : cnt_tgl_q + 24'd1;
        if (cnt_win_q == BOUNCE_CNT) begin
          state_d   = IDLE;
          key_out_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_win_d = '0;
          cnt_tgl_d = '0;
        end else if (tgl_wrap && tgl_en) begin
          key_out_d = ~key_out_q;
        end
      end
      default: begin
        // Recover from an illegal one-hot code to a released, idle key.
        state_d   = IDLE;
        cnt_win_d = '0;
        key_out_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_win_q <= '0;
      cnt_tgl_q <= '0;
      key_out_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_win_q <= cnt_win_d;
      cnt_tgl_q <= cnt_tgl_d;
      key_out_q <= key_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign kb.key_out = key_out_q;
  assign kb.busy    = busy_q;
  assign kb.done    = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboard bench for key_bounce_gen with small timing parameters (honours RANDOM_BOUNCE_EN).
module tb_key_bounce_gen;

  localparam int P   = 10;      // bounce window length
  localparam int H   = 20;      // hold length
  localparam int D   = 3;       // toggle period
  localparam int LEN = 2*P + H; // press_req to done

  logic sys_clk;
  logic sys_rst_n;
  key_bounce_if kb ();

  key_bounce_gen #(
    .BOUNCE_CNT (24'(P - 1)),
    .HOLD_CNT   (24'(H - 1)),
    .TOGGLE_DIV (24'(D - 1))
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .kb        (kb)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_chk;
  int          n_fail;
  int          n_done;
  int          m_t;      // edges since the accepted press_req, -1 when idle
  logic        m_key;
  logic [15:0] m_lfsr;
  logic [2:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t    = -1;
    m_key  = 1'b1;
    m_lfsr = 16'hACE1;
    exp_q.delete();
  endtask

  // Expected {key_out, busy, done} just after a clock edge with the given request.
  task automatic model_step(input logic req);
    logic tg;
    tg = 1'b1;
`ifdef RANDOM_BOUNCE_EN
    tg     = m_lfsr[0];
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    if ((m_t < 0 || m_t == LEN) && req) begin
      m_t   = 0;
      m_key = 1'b0;
    end else if (m_t == LEN) begin
      m_t   = -1;
      m_key = 1'b1;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t < P) begin
        if ((m_t - 1) % D == D - 1 && tg) m_key = ~m_key;
      end else if (m_t < P + H) begin
        m_key = 1'b0;
      end else if (m_t == P + H) begin
        m_key = 1'b1;
      end else if (m_t < LEN) begin
        if ((m_t - P - H - 1) % D == D - 1 && tg) m_key = ~m_key;
      end else begin
        m_key = 1'b1;
      end
    end
    exp_q.push_back({m_key, (m_t >= 0 && m_t < LEN), (m_t == LEN)});
  endtask

  task automatic cyc(input logic req);
    logic [2:0] e;
    kb.press_req = req;
    @(posedge sys_clk);
    model_step(req);
    @(negedge sys_clk);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("cyc", 32'({kb.key_out, kb.busy, kb.done}), 32'(e));
    end
    if (kb.done) n_done++;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_done = 0;
    sys_rst_n    = 1'b0;
    kb.press_req = 1'b0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    chk("rst_key",  32'(kb.key_out), 32'd1);
    chk("rst_busy", 32'(kb.busy),    32'd0);
    chk("rst_done", 32'(kb.done),    32'd0);
    sys_rst_n = 1'b1;
    repeat (3) cyc(1'b0);

    // single sequence
    n_done = 0;
    cyc(1'b1);
    for (int i = 1; i <= LEN + 5; i++) cyc(1'b0);
    chk("done_cnt_single", 32'(n_done), 32'd1);

    // requests while busy are ignored
    n_done = 0;
    cyc(1'b1);
    for (int i = 1; i <= LEN + 5; i++) cyc(i == 5 || i == 30);
    chk("done_cnt_ignored", 32'(n_done), 32'd1);

    // request in the done cycle starts the next sequence
    n_done = 0;
    cyc(1'b1);
    for (int i = 1; i <= LEN; i++) cyc(1'b0);
    cyc(1'b1);
    for (int i = 1; i <= LEN + 5; i++) cyc(1'b0);
    chk("done_cnt_backtoback", 32'(n_done), 32'd2);

    // async reset in HOLD
    n_done = 0;
    cyc(1'b1);
    for (int i = 1; i <= 15; i++) cyc(1'b0);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_key",  32'(kb.key_out), 32'd1);
    chk("arst_busy", 32'(kb.busy),    32'd0);
    chk("arst_done", 32'(kb.done),    32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) cyc(1'b0);
    chk("done_cnt_after_arst", 32'(n_done), 32'd0);
    cyc(1'b1);
    for (int i = 1; i <= LEN + 5; i++) cyc(1'b0);
    chk("done_cnt_rerun", 32'(n_done), 32'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
